// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM state type for the single-precision multiply path.
// The rounding stage consumes PROD_W bits and produces FRAC_W fraction bits.
package fp_mul_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mant_mul_seq_if.sv
// Operand/product handshake bundle between the multiplier and its neighbours.
// master drives operands and out_ready; slave (the multiplier) drives the rest.
interface mant_mul_seq_if #(
  parameter int MANT_W = fp_mul_pkg::MANT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_W-1:0]     mant_a;
  logic [MANT_W-1:0]     mant_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*MANT_W-1:0]   product;
  logic                  busy;

  modport master (
    output in_valid, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mant_a, mant_b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mant_mul_pp_sel.sv
// Partial-product select for the shift-and-add multiplier.
// MANT_MUL_RADIX4_EN selects the 0/1x/2x/3x radix-4 mux instead of radix-2 gating.
module mant_mul_pp_sel #(
  parameter int PROD_W = fp_mul_pkg::PROD_W
) (
`ifdef MANT_MUL_RADIX4_EN
  input  logic [PROD_W-1:0] mcand,
  input  logic [PROD_W-1:0] mcand3,
  input  logic [1:0]        mbits,
`else
  input  logic [PROD_W-1:0] mcand,
  input  logic              mbit,
`endif
  output logic [PROD_W-1:0] pp
);

`ifdef MANT_MUL_RADIX4_EN
  always_comb begin
    pp = '0;
    case (mbits)
      2'd0:    pp = '0;
      2'd1:    pp = mcand;
      2'd2:    pp = mcand << 1;
      default: pp = mcand3;
    endcase
  end
`else
  assign pp = mbit ? mcand : '0;
`endif

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential unsigned significand multiplier: full 2*MANT_W-bit product by shift-and-add.
// Build option MANT_MUL_RADIX4_EN retires two multiplier bits per cycle (MANT_W/2 cycles).
module mant_mul_seq #(
  parameter int MANT_W = fp_mul_pkg::MANT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mant_mul_seq_if.slave       bus
);

  import fp_mul_pkg::*;

  localparam int PROD_BITS = 2 * MANT_W;
`ifdef MANT_MUL_RADIX4_EN
  localparam int STEP_SH = 2;
`else
  localparam int STEP_SH = 1;
`endif
  localparam int STEPS = MANT_W / STEP_SH;
  localparam int CNT_W = $clog2(STEPS + 1);

`ifdef MANT_MUL_RADIX4_EN
  generate
    if (MANT_W % 2 != 0) begin : g_odd_width
      $error("mant_mul_seq: radix-4 build needs an even MANT_W");
    end
  endgenerate
`endif

  state_t                 state_q, state_d;
  logic [PROD_BITS-1:0]   mcand_q, mcand_d;
  logic [MANT_W-1:0]      mplier_q, mplier_d;
  logic [PROD_BITS-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [PROD_BITS-1:0]   pp;
`ifdef MANT_MUL_RADIX4_EN
  logic [PROD_BITS-1:0]   mcand3_q, mcand3_d;

  mant_mul_pp_sel #(.PROD_W(PROD_BITS)) u_pp_sel (
    .mcand  (mcand_q),
    .mcand3 (mcand3_q),
    .mbits  (mplier_q[1:0]),
    .pp     (pp)
  );
`else
  mant_mul_pp_sel #(.PROD_W(PROD_BITS)) u_pp_sel (
    .mcand  (mcand_q),
    .mbit   (mplier_q[0]),
    .pp     (pp)
  );
`endif

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
`ifdef MANT_MUL_RADIX4_EN
    mcand3_d    = mcand3_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = PROD_BITS'(bus.mant_a);
          mplier_d = bus.mant_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef MANT_MUL_RADIX4_EN
          mcand3_d = PROD_BITS'(bus.mant_a) + (PROD_BITS'(bus.mant_a) << 1);
`endif
        end
      end
      CALC: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << STEP_SH;
        mplier_d = mplier_q >> STEP_SH;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MANT_MUL_RADIX4_EN
        mcand3_d = mcand3_q << STEP_SH;
`endif
        // No early exit: latency is fixed regardless of operand values.
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef MANT_MUL_RADIX4_EN
      mcand3_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
`ifdef MANT_MUL_RADIX4_EN
      mcand3_q    <= mcand3_d;
`endif
    end
  end

  // Product comes straight from the accumulator; it is frozen once in DONE.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;

endmodule
